// File: rtl/pri_arb_pkg.sv
// Shared definitions for the priority encoder/arbiter family:
// FSM state encoding and arbitration mode constants.
package pri_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

endpackage

// File: rtl/pri_encoder_arb_if.sv
// Request/grant bundle between requesters/consumer (master) and the
// arbiter (slave).
interface pri_encoder_arb_if #(
    parameter int N_CH  = 8,
    parameter int IDX_W = $clog2(N_CH)
);
    logic [N_CH-1:0]  iReq;
    logic             iMode;
    logic             iAck;
    logic             oValid;
    logic [IDX_W-1:0] oIdx;
    logic [N_CH-1:0]  oGrant;
    logic             oBusy;

    modport master (
        output iReq, iMode, iAck,
        input  oValid, oIdx, oGrant, oBusy
    );

    modport slave (
        input  iReq, iMode, iAck,
        output oValid, oIdx, oGrant, oBusy
    );
endinterface

// File: rtl/pri_pick.sv
// Combinational winner selection: lowest set request in fixed mode, or the
// first set request at/after ptr (wrapping at N_CH-1) in round-robin mode.
module pri_pick
    import pri_arb_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    input  mode_e            mode,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        // NOTE: defaults first so every path assigns any/idx and no latch is inferred.
        any = 1'b0;
        idx = '0;
        // Walk offsets from the far end down so the nearest hit is written last.
        for (int k = N_CH - 1; k >= 0; k--) begin
            int c;
            c = ((mode == MODE_RR) ? int'(ptr) : 0) + k;
            if (c >= N_CH) c = c - N_CH;
            if (req[c]) begin
                any = 1'b1;
                idx = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/pri_encoder_arb.sv
// Registered priority encoder/arbiter: grants one requester, holds the grant
// until acknowledged, and re-arbitrates on the ack edge without a bubble.
module pri_encoder_arb
    import pri_arb_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int IDX_W = $clog2(N_CH)
) (
    input  logic              iClk,
    input  logic              iRst_n,
    pri_encoder_arb_if.slave  bus
);

    state_e            r_state;
    logic              r_valid;
    logic [IDX_W-1:0]  r_idx;
    logic [N_CH-1:0]   r_grant;
    logic [IDX_W-1:0]  r_ptr;

    mode_e             w_mode;
    logic [IDX_W-1:0]  w_ptr_next;
    logic [IDX_W-1:0]  w_ptr_sel;
    logic              w_any;
    logic [IDX_W-1:0]  w_idx;
    logic [N_CH-1:0]   w_grant;

    assign w_mode     = mode_e'(bus.iMode);
    assign w_ptr_next = (r_idx == IDX_W'(N_CH - 1)) ? '0 : r_idx + IDX_W'(1);
    // On an ack edge the pick must already see the advanced pointer.
    assign w_ptr_sel  = (r_state == ST_GRANT) ? w_ptr_next : r_ptr;
    assign w_grant    = N_CH'(1) << w_idx;

    pri_pick #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_pick (
        .req  (bus.iReq),
        .ptr  (w_ptr_sel),
        .mode (w_mode),
        .any  (w_any),
        .idx  (w_idx)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_GRANT;
                        r_valid <= 1'b1;
                        r_idx   <= w_idx;
                        r_grant <= w_grant;
                    end
                end
                ST_GRANT: begin
                    if (bus.iAck) begin
                        r_ptr <= w_ptr_next;
                        if (w_any) begin
                            r_idx   <= w_idx;
                            r_grant <= w_grant;
                        end else begin
                            r_state <= ST_IDLE;
                            r_valid <= 1'b0;
                            r_grant <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign bus.oValid = r_valid;
    assign bus.oIdx   = r_idx;
    assign bus.oGrant = r_grant;
    assign bus.oBusy  = (r_state == ST_GRANT);

endmodule

// File: doc/pri_encoder_arb.md
Name: pri_encoder_arb

Overview:
Registered, parametrised priority encoder/arbiter; the sequential successor to the team's 4-input select-style encoder. Takes N_CH request lines and produces a registered winner index plus a one-hot grant. Supports fixed-priority and round-robin modes. A grant is held until the consumer acknowledges it. Sits in front of shared resources (bus masters, shared ports) wherever several requesters contend.

Parameters:
N_CH, 8, number of request channels (2..32; non-power-of-two allowed)
IDX_W, $clog2(N_CH), width of winner index (derived; not overridden)

Ports:
iClk  input  1  clock, rising edge
iRst_n  input  1  asynchronous active-low reset
iReq  input  N_CH  level request per channel
iMode  input  1  0 = fixed priority (index 0 highest), 1 = round-robin
iAck  input  1  consumer accepts current grant; meaningful only while oValid=1
oValid  output  1  a grant is being presented
oIdx  output  IDX_W  index of granted channel
oGrant  output  N_CH  one-hot grant; all zero when oValid=0
oBusy  output  1  high in GRANT state (equals oValid)

Behaviour:
- Interface: one clock iClk; reset iRst_n is asynchronous and active-low.
- Reset (async assert, sync release): state=IDLE, oValid=0, oIdx=0, oGrant=0, RR pointer=0. Applies immediately, including mid-grant; the pending grant is discarded with no ack needed.
- States: IDLE, GRANT. All outputs are registered.
- Arbitration function:
  - Fixed mode: lowest set index of iReq.
  - RR mode: first set bit searching upward from the pointer, wrapping N_CH-1 -> 0.
- IDLE:
  - If iReq != 0 at a rising edge, go to GRANT. oValid=1, oIdx=winner and oGrant=1<<winner are visible after that edge (latency 1 cycle).
  - If iReq == 0, remain in IDLE.
- GRANT, iAck=0:
  - Hold oIdx and oGrant unchanged (lock), even if the granted request drops or a higher-priority request rises.
- GRANT, iAck=1:
  - The grant completes.
  - RR pointer <= (oIdx==N_CH-1) ? 0 : oIdx+1.
  - Re-arbitrate in the same edge using the current iReq and the updated pointer (current iMode). If any request is present, stay in GRANT with the new winner (back-to-back, no bubble); otherwise go to IDLE with oValid=0 and oGrant=0.
  - In fixed mode, a still-asserted channel may win again.
  - The acked channel is not masked; fairness comes only from the RR pointer.
- iAck while IDLE is ignored.
- iMode is sampled only at arbitration edges (IDLE->GRANT or on ack). A change during a held grant takes effect at the next arbitration.
- The pointer updates on every ack in either mode, so switching to RR continues from the last served channel+1.
- oIdx holds its last value in IDLE. Consumers qualify it with oValid.
- Invariant: oGrant == (oValid ? 1<<oIdx : 0).

Decomposition:
- Shared package pri_arb_pkg: state encoding (ST_IDLE, ST_GRANT); mode constants (MODE_FIXED=0, MODE_RR=1).
- One combinational sub-module pri_pick (parameters N_CH, IDX_W). Inputs: req, ptr, mode. Outputs: any, idx.
- pri_pick is reused by later multi-channel encoders. The top level holds only the FSM, the pointer register and the output registers.

Test Plan:
1. Reset mid-grant: grant active on ch3, pull iRst_n low between clock edges -> oValid=0, oGrant=0, oIdx=0 immediately. After release with iReq=0, stays IDLE.
2. Fixed mode, N_CH=8, iReq=8'h24 -> one edge later oValid=1, oIdx=2, oGrant=8'h04. Held for 5 cycles with iAck=0. Ack with iReq still 8'h24 -> next cycle oIdx=2 again, with no idle bubble.
3. RR mode, iReq=8'hFF constant, iAck=1 every cycle -> oIdx sequence 0,1,2,...,7,0,1, oValid continuously 1.
4. Lock and drop: grant on ch3 (iReq=8'h08), then iReq changes to 8'h01 with iAck=0 -> oIdx stays 3. On ack -> oIdx=0. Next ack with iReq=0 -> IDLE, oValid=0.
5. Non-power-of-two wrap, N_CH=5, RR mode, iReq=5'b10001, ack each grant -> oIdx sequence 0,4,0,4. Pointer goes 4 -> 0 after ch4 (wrap at 4, never 5..7).
6. Mode switch: RR grant on ch2 held, iMode toggled to 0 while iReq=8'h84 -> oIdx stays 2 until ack. The following arbitration uses fixed mode and picks ch2.
